// File: rtl/priority_source_bank.sv
// priority_source_bank
// Requester-side front end for the priority multiplexer. Each source channel
// owns a small FIFO of {priority, data} words; the head word of every channel
// is presented on the request bus together with an aged effective priority.
// An ack from the multiplexer retires the head word. Aging boosts the priority
// of a head word that has been waiting for a long time so that low-priority
// sources cannot starve.

module priority_source_bank #(
    parameter int N_PRIORITY_WIDTH = 3,
    parameter int N_SIGNAL_WIDTH   = 8,
    parameter int N_SIGNALS        = 8,
    parameter int FIFO_DEPTH       = 4,
    parameter int AGE_LIMIT        = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_SIGNALS-1:0]                   wr_en,
    input  logic [N_SIGNAL_WIDTH*N_SIGNALS-1:0]    wr_data,
    input  logic [N_PRIORITY_WIDTH*N_SIGNALS-1:0]  wr_priority,
    output logic [N_SIGNALS-1:0]                   wr_ready,
    output logic [N_SIGNAL_WIDTH*N_SIGNALS-1:0]    signals_out,
    output logic [N_PRIORITY_WIDTH*N_SIGNALS-1:0]  priorities_out,
    output logic [N_SIGNALS-1:0]                   signal_req,
    input  logic [N_SIGNALS-1:0]                   signal_ack,
    output logic                                   busy,
    output logic [N_SIGNALS-1:0]                   overflow,
    output logic [N_SIGNALS-1:0]                   ack_err
);

    localparam int PW      = N_PRIORITY_WIDTH;
    localparam int DW      = N_SIGNAL_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int AGE_W   = $clog2(AGE_LIMIT) + 1;
    localparam int ENTRY_W = PW + DW;

    localparam logic [PW-1:0]    PRIO_MAX   = {PW{1'b1}};
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [AGE_W-1:0] AGE_WRAP_V = AGE_W'(AGE_LIMIT - 1);

    for (genvar i = 0; i < N_SIGNALS; i++) begin : g_chan

        // Channel storage and bookkeeping
        logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]   wr_ptr;
        logic [PTR_W-1:0]   rd_ptr;
        logic [CNT_W-1:0]   count;
        logic [AGE_W-1:0]   age;
        logic [PW-1:0]      boost;
        logic               ovf_flag;
        logic               aerr_flag;

        // Decoded per-cycle control and head view
        logic               full;
        logic               empty;
        logic               push;
        logic               pop;
        logic               age_wrap;
        logic               can_boost;
        logic [ENTRY_W-1:0] head;
        logic [PW-1:0]      head_prio;
        logic [DW-1:0]      head_data;
        logic [PW:0]        eff_sum;
        logic [PW-1:0]      eff_prio;

        // Channel decode: handshake qualification, head fields, saturated priority
        always_comb begin
            // NOTE: every always_comb output gets a value on every path; here each is assigned unconditionally, so no latch is inferred.
            full      = (count == CNT_FULL);
            empty     = (count == '0);
            push      = wr_en[i] && !full;
            pop       = signal_ack[i] && !empty;
            head      = mem[rd_ptr];
            head_prio = head[ENTRY_W-1 -: PW];
            head_data = head[DW-1:0];
            // One extra bit keeps the carry, then the sum is clamped to the top level.
            eff_sum   = {1'b0, head_prio} + {1'b0, boost};
            eff_prio  = (eff_sum > {1'b0, PRIO_MAX}) ? PRIO_MAX : eff_sum[PW-1:0];
            age_wrap  = (age == AGE_WRAP_V);
            can_boost = (eff_sum < {1'b0, PRIO_MAX});
        end

        // Word storage written on an accepted push
        always_ff @(posedge clk) begin
            // NOTE: the data array has no reset; entries are only ever read behind a non-zero count, so reset would add fan-out for nothing.
            if (push) begin
                mem[wr_ptr] <= {wr_priority[i*PW +: PW], wr_data[i*DW +: DW]};
            end
        end

        // Pointers and occupancy count
        always_ff @(posedge clk or posedge rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // Head aging: count waiting cycles, bump boost on each wrap, clear on pop
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                age   <= '0;
                boost <= '0;
            end else if (pop) begin
                age   <= '0;
                boost <= '0;
            end else if (!empty) begin
                if (age_wrap) begin
                    age <= '0;
                    if (can_boost) boost <= boost + PW'(1);
                end else begin
                    age <= age + AGE_W'(1);
                end
            end
        end

        // Sticky protocol-violation flags, cleared only by reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ovf_flag  <= 1'b0;
                aerr_flag <= 1'b0;
            end else begin
                if (wr_en[i] && full)       ovf_flag  <= 1'b1;
                if (signal_ack[i] && empty) aerr_flag <= 1'b1;
            end
        end

        // Request-bus view; empty channels show zero fields
        assign wr_ready[i]                 = !full;
        assign signal_req[i]               = !empty;
        assign signals_out[i*DW +: DW]     = empty ? '0 : head_data;
        assign priorities_out[i*PW +: PW]  = empty ? '0 : eff_prio;
        assign overflow[i]                 = ovf_flag;
        assign ack_err[i]                  = aerr_flag;
    end

    // Bank is busy whenever any channel requests
    always_comb begin
        busy = |signal_req;
    end

endmodule

// File: tb/tb_priority_source_bank.sv
// Directed testbench for priority_source_bank with default parameters
// (3-bit priority, 8-bit data, 8 channels, depth 4, age limit 16).

module tb_priority_source_bank;

    localparam int PW = 3;
    localparam int DW = 8;
    localparam int NS = 8;

    logic            clk;
    logic            rst;
    logic [NS-1:0]   wr_en;
    logic [DW*NS-1:0] wr_data;
    logic [PW*NS-1:0] wr_priority;
    logic [NS-1:0]   wr_ready;
    logic [DW*NS-1:0] signals_out;
    logic [PW*NS-1:0] priorities_out;
    logic [NS-1:0]   signal_req;
    logic [NS-1:0]   signal_ack;
    logic            busy;
    logic [NS-1:0]   overflow;
    logic [NS-1:0]   ack_err;

    int errors = 0;
    int checks = 0;

    priority_source_bank #(
        .N_PRIORITY_WIDTH(PW),
        .N_SIGNAL_WIDTH  (DW),
        .N_SIGNALS       (NS),
        .FIFO_DEPTH      (4),
        .AGE_LIMIT       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_priority   (wr_priority),
        .wr_ready      (wr_ready),
        .signals_out   (signals_out),
        .priorities_out(priorities_out),
        .signal_req    (signal_req),
        .signal_ack    (signal_ack),
        .busy          (busy),
        .overflow      (overflow),
        .ack_err       (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling / driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] head_data(input int ch);
        return signals_out[ch*DW +: DW];
    endfunction

    function automatic logic [PW-1:0] head_prio(input int ch);
        return priorities_out[ch*PW +: PW];
    endfunction

    task automatic set_push(input int ch, input logic [DW-1:0] d, input logic [PW-1:0] p);
        wr_en[ch]             = 1'b1;
        wr_data[ch*DW +: DW]  = d;
        wr_priority[ch*PW +: PW] = p;
    endtask

    initial begin
        rst         = 1'b1;
        wr_en       = '0;
        wr_data     = '0;
        wr_priority = '0;
        signal_ack  = '0;

        // ---------------- Reset state ----------------
        #2;
        check("rst_req",      signal_req,     0);
        check("rst_busy",     busy,           0);
        check("rst_ready",    wr_ready,       8'hFF);
        check("rst_data",     signals_out,    0);
        check("rst_prio",     priorities_out, 0);
        check("rst_ovf",      overflow,       0);
        check("rst_aerr",     ack_err,        0);
        step();
        rst = 1'b0;
        step();

        // ---------------- 1. single push / ack ----------------
        set_push(5, 8'h2A, 3'd3);
        step();
        wr_en = '0;
        check("t1_req",   signal_req, 8'b0010_0000);
        check("t1_busy",  busy, 1);
        check("t1_data",  head_data(5), 8'h2A);
        check("t1_prio",  head_prio(5), 3);
        signal_ack = 8'h20;
        step();
        signal_ack = '0;
        check("t1_req_after_ack",  signal_req, 0);
        check("t1_busy_after_ack", busy, 0);
        check("t1_data_after_ack", signals_out, 0);

        // ---------------- 2. fill, overflow, drain ----------------
        for (int k = 0; k < 5; k++) begin
            set_push(0, 8'(8'h10 + k), 3'd2);
            step();
            check($sformatf("t2_ready_after_push%0d", k + 1), wr_ready[0], (k < 3) ? 1 : 0);
            check($sformatf("t2_ovf_after_push%0d", k + 1),   overflow[0], (k == 4) ? 1 : 0);
        end
        wr_en = '0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_head%0d", k), head_data(0), 8'(8'h10 + k));
            signal_ack[0] = 1'b1;
            step();
        end
        signal_ack = '0;
        check("t2_req_drained",   signal_req[0], 0);
        check("t2_ready_drained", wr_ready[0],   1);

        // ---------------- 3. push and pop together ----------------
        set_push(1, 8'h30, 3'd1);
        step();
        set_push(1, 8'h31, 3'd1);
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_head_before_pp%0d", k), head_data(1), 8'(8'h30 + k));
            set_push(1, 8'(8'h32 + k), 3'd1);
            signal_ack[1] = 1'b1;
            step();
            check($sformatf("t3_ready_pp%0d", k), wr_ready[1], 1);
        end
        signal_ack = '0;
        // FIFO now holds 0x33, 0x34; fill to full
        set_push(1, 8'h35, 3'd1);
        step();
        set_push(1, 8'h36, 3'd1);
        step();
        wr_en = '0;
        check("t3_full_ready", wr_ready[1], 0);
        check("t3_full_head",  head_data(1), 8'h33);
        // Push at full with ack: push dropped, count 4 -> 3
        set_push(1, 8'h37, 3'd1);
        signal_ack[1] = 1'b1;
        step();
        wr_en = '0;
        check("t3_ready_after_full_pp", wr_ready[1], 1);
        check("t3_ovf_after_full_pp",   overflow[1], 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_drain_head%0d", k), head_data(1), 8'(8'h34 + k));
            step();
        end
        signal_ack = '0;
        check("t3_req_drained", signal_req[1], 0);

        // ---------------- 4. aging ----------------
        set_push(2, 8'h55, 3'd1);
        step();                       // edge e0: word visible
        check("t4_prio_e0", head_prio(2), 1);
        set_push(2, 8'h56, 3'd4);
        step();                       // edge e1: second word queued, aging continues
        wr_en = '0;
        repeat (14) step();           // edge e15
        check("t4_prio_15", head_prio(2), 1);
        step();                       // edge e16
        check("t4_prio_16", head_prio(2), 2);
        repeat (15) step();
        check("t4_prio_31", head_prio(2), 2);
        step();                       // edge e32
        check("t4_prio_32", head_prio(2), 3);
        repeat (48) step();           // edge e80
        check("t4_prio_80", head_prio(2), 6);
        repeat (16) step();           // edge e96
        check("t4_prio_96", head_prio(2), 7);
        repeat (32) step();
        check("t4_prio_sat", head_prio(2), 7);
        check("t4_data_held", head_data(2), 8'h55);
        signal_ack[2] = 1'b1;
        step();
        signal_ack = '0;
        check("t4_next_data", head_data(2), 8'h56);
        check("t4_next_prio", head_prio(2), 4);
        signal_ack[2] = 1'b1;
        step();
        signal_ack = '0;
        check("t4_req_drained", signal_req[2], 0);

        // ---------------- 5. spurious ack ----------------
        set_push(3, 8'h77, 3'd5);
        step();
        wr_en = '0;
        signal_ack = 8'h80;
        step();
        signal_ack = '0;
        check("t5_aerr",     ack_err,        8'h80);
        check("t5_req",      signal_req,     8'h08);
        check("t5_ch3_data", head_data(3),   8'h77);
        check("t5_ovf",      overflow,       8'h03);

        // ---------------- 6. async reset mid-drain ----------------
        set_push(3, 8'h78, 3'd5);
        step();
        set_push(3, 8'h79, 3'd5);
        step();
        wr_en = '0;
        signal_ack[3] = 1'b1;
        step();
        check("t6_head_mid_drain", head_data(3), 8'h78);
        #2;
        rst = 1'b1;
        #1;
        check("t6_req",   signal_req,     0);
        check("t6_busy",  busy,           0);
        check("t6_data",  signals_out,    0);
        check("t6_prio",  priorities_out, 0);
        check("t6_ovf",   overflow,       0);
        check("t6_aerr",  ack_err,        0);
        check("t6_ready", wr_ready,       8'hFF);
        signal_ack = '0;
        step();
        rst = 1'b0;
        step();
        check("t6_req_after_release", signal_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
